seq_alu: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle datapath ALU. Keeps the
//  AND/OR/ADD/SUB/SLT/NOR op codes and adds signed overflow, iterative unsigned

---
 rtl/seq_alu.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//
// Handshaked sequential ALU. It accepts one operation at a time, either
// completes it in a single cycle (logic, add/sub, set-less-than, unsupported
// codes) or iterates over WIDTH cycles (unsigned multiply, optional unsigned
// divide). It then holds the result until the consumer takes it.
//
// Optional feature macro: SEQ_ALU_DIV_EN
//   defined     -> DIVU (4'b1010) implemented as a restoring divider and
//                  div_by_zero is active.
//   not defined -> no divider logic; 4'b1010 behaves as an unsupported code
//                  and div_by_zero is tied low.
//
// Handshake: a request is accepted on a rising edge where in_valid && in_ready.
//   in_ready is high only in IDLE. A result is offered while out_valid is high,
//   which happens only in DONE. It is consumed on the edge where
//   out_valid && out_ready. Outputs and flags stay stable until that edge.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous active-low reset
//   in_valid     in   1      request valid
//   in_ready     out  1      request can be accepted (IDLE)
//   opA, opB     in   WIDTH  operands, latched on accept
//   ALUop        in   4      operation code
//   out_valid    out  1      result valid (DONE)
//   out_ready    in   1      consumer accepts result
//   result       out  WIDTH  low product / quotient / single-cycle result
//   result_hi    out  WIDTH  high product / remainder, 0 for single-cycle ops
//   zero         out  1      result == 0
//   overflow     out  1      signed overflow of ADD/SUB
//   div_by_zero  out  1      DIVU with opB == 0
//   dbg_state_o  out  2      current FSM state (IDLE=0, BUSY=1, DONE=2)
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [3:0]       ALUop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state_o
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MULU = 4'b1000;
`ifdef SEQ_ALU_DIV_EN
   localparam logic [3:0] OP_DIVU = 4'b1010;
`endif

   localparam int MSB = WIDTH - 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [WIDTH-1:0]  hi_q, hi_d;    // result_hi, or partial product / remainder
   logic [WIDTH-1:0]  lo_q, lo_d;    // result, or multiplier / dividend-quotient
   logic [WIDTH-1:0]  b_q, b_d;      // latched multiplicand / divisor
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              zero_q, zero_d;
   logic              ovf_q, ovf_d;
   logic              dbz_q, dbz_d;
`ifdef SEQ_ALU_DIV_EN
   logic              is_div_q, is_div_d;
`endif

   // ---------------------------------------------------------------------------
   // Single-cycle datapath, evaluated on the live inputs at accept time
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] sum, diff;
   logic             add_ovf, sub_ovf, slt_bit;

   assign sum  = opA + opB;
   assign diff = opA - opB;
   // For SUB the second addend is ~B, so the operand sign test inverts.
   assign add_ovf = (opA[MSB] == opB[MSB]) && (sum[MSB]  != opA[MSB]);
   assign sub_ovf = (opA[MSB] != opB[MSB]) && (diff[MSB] != opA[MSB]);
   // Signed A < B: sign of A-B corrected by overflow.
   assign slt_bit = diff[MSB] ^ sub_ovf;

   // Decode of an incoming request into what gets latched on accept.
   logic [WIDTH-1:0] dec_lo, dec_hi;
   logic             dec_ovf, dec_dbz, dec_multi;
`ifdef SEQ_ALU_DIV_EN
   logic             dec_div;
`endif

   always_comb begin
      dec_lo    = '0;
      dec_hi    = '0;
      dec_ovf   = 1'b0;
      dec_dbz   = 1'b0;
      dec_multi = 1'b0;
`ifdef SEQ_ALU_DIV_EN
      dec_div   = 1'b0;
`endif
      case (ALUop)
         OP_AND: dec_lo = opA & opB;
         OP_OR:  dec_lo = opA | opB;
         OP_NOR: dec_lo = ~(opA | opB);
         OP_ADD: begin
            dec_lo  = sum;
            dec_ovf = add_ovf;
         end
         OP_SUB: begin
            dec_lo  = diff;
            dec_ovf = sub_ovf;
         end
         OP_SLT: dec_lo = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_MULU: begin
            // lo holds the multiplier and is shifted out LSB first.
            dec_lo    = opA;
            dec_multi = 1'b1;
         end
`ifdef SEQ_ALU_DIV_EN
         OP_DIVU: begin
            if (opB == '0) begin
               // Division by zero finishes immediately with a fixed answer.
               dec_lo  = '1;
               dec_hi  = opA;
               dec_dbz = 1'b1;
            end else begin
               // lo holds the dividend; quotient bits shift in from the right.
               dec_lo    = opA;
               dec_multi = 1'b1;
               dec_div   = 1'b1;
            end
         end
`endif
         default: dec_lo = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Iterative step, one per BUSY cycle
   // ---------------------------------------------------------------------------
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi, step_lo;

   // Shift-add: add B into the upper half when the current multiplier bit is
   // set, then shift {carry, hi, lo} right by one.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0] div_trial;
   // Remainder is always < divisor, so the top bit of the trial difference is
   // exactly its sign.
   assign div_trial = {hi_q, lo_q[MSB]} - {1'b0, b_q};
`endif

   always_comb begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
      if (is_div_q) begin
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = {hi_q[WIDTH-2:0], lo_q[MSB]};
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
`ifdef SEQ_ALU_DIV_EN
      is_div_d = is_div_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               lo_d   = dec_lo;
               hi_d   = dec_hi;
               b_d    = opB;
               ovf_d  = dec_ovf;
               dbz_d  = dec_dbz;
               cnt_d  = '0;
`ifdef SEQ_ALU_DIV_EN
               is_div_d = dec_div;
`endif
               if (dec_multi) begin
                  zero_d  = 1'b0;
                  state_d = S_BUSY;
               end else begin
                  zero_d  = (dec_lo == '0);
                  state_d = S_DONE;
               end
            end
         end
         S_BUSY: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               cnt_d   = '0;
               zero_d  = (step_lo == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_ALU_DIV_EN
         is_div_q <= is_div_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign result      = lo_q;
   assign result_hi   = hi_q;
   assign zero        = zero_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//
// Directed and randomized requests for seq_alu (WIDTH=32). Expected values come
// from a behavioural model using wide integer arithmetic; expected results are
// queued when a request is issued and popped when the result is offered.
// -----------------------------------------------------------------------------
module tb_seq_alu;

   localparam int W = 32;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  opA, opB, result, result_hi;
   logic [3:0]    ALUop;
   logic          zero, overflow, div_by_zero;
   logic [1:0]    dbg_state;

   seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opA         (opA),
      .opB         (opB),
      .ALUop       (ALUop),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .result_hi   (result_hi),
      .zero        (zero),
      .overflow    (overflow),
      .div_by_zero (div_by_zero),
      .dbg_state_o (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_hi_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [W-1:0] hi,
                        output logic z, output logic ov, output logic dz,
                        output int lat);
      longint sa, sb, s;
      longint maxv, minv;
      logic [63:0] p;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      maxv = 2147483647;
      minv = -maxv - 1;
      r = '0; hi = '0; ov = 1'b0; dz = 1'b0; lat = 1;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0010: begin
            s  = sa + sb;
            r  = s[W-1:0];
            ov = (s > maxv) || (s < minv);
         end
         4'b0110: begin
            s  = sa - sb;
            r  = s[W-1:0];
            ov = (s > maxv) || (s < minv);
         end
         4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b1000: begin
            p   = {32'b0, a} * {32'b0, b};
            r   = p[31:0];
            hi  = p[63:32];
            lat = W + 1;
         end
`ifdef SEQ_ALU_DIV_EN
         4'b1010: begin
            if (b == 0) begin
               r  = '1;
               hi = a;
               dz = 1'b1;
            end else begin
               r   = a / b;
               hi  = a % b;
               lat = W + 1;
            end
         end
`endif
         default: r = '0;
      endcase
      z = (r == 0);
   endtask

   // ---------------------------------------------------------------------------
   // Driver: issue one request, check latency/result, hold backpressure, release
   // ---------------------------------------------------------------------------
   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      logic [W-1:0] r_e, hi_e, r_x, hi_x;
      logic z_e, ov_e, dz_e, busy_ok, stable;
      int lat_e, lat;
      model(op, a, b, r_e, hi_e, z_e, ov_e, dz_e, lat_e);
      exp_q.push_back(r_e);
      exp_hi_q.push_back(hi_e);

      // Called at a negedge while the DUT sits in IDLE.
      chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; opA = a; opB = b; ALUop = op;
      @(posedge clk);
      #1;
      in_valid = 1'b0; opA = $urandom; opB = $urandom; ALUop = 4'($urandom_range(0, 15));

      lat = 0;
      busy_ok = 1'b1;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (in_ready) busy_ok = 1'b0;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(lat_e));
      chk({tag, ".in_ready_busy"}, 64'(busy_ok), 64'd1);

      r_x  = exp_q.pop_front();
      hi_x = exp_hi_q.pop_front();
      chk({tag, ".result"}, 64'(result), 64'(r_x));
      chk({tag, ".result_hi"}, 64'(result_hi), 64'(hi_x));
      chk({tag, ".zero"}, 64'(zero), 64'(z_e));
      chk({tag, ".overflow"}, 64'(overflow), 64'(ov_e));
      chk({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(dz_e));

      // Backpressure: random request pulses must be ignored and outputs held.
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         opA = $urandom; opB = $urandom; ALUop = 4'($urandom_range(0, 15));
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r_x ||
             result_hi !== hi_x || zero !== z_e || overflow !== ov_e)
            stable = 1'b0;
      end
      in_valid = 1'b0;
      if (hold > 0) chk({tag, ".held"}, 64'(stable), 64'd1);

      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
      chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [3:0] op_tab [10];
   logic       saw_valid;

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      op_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                 4'b1100, 4'b1000, 4'b1010, 4'b0011, 4'b1111};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      opA = '0; opB = '0; ALUop = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.result", 64'(result), 64'd0);
      chk("rst.result_hi", 64'(result_hi), 64'd0);
      chk("rst.flags", 64'({zero, overflow, div_by_zero}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a multiply
      in_valid = 1'b1; opA = 32'hFFFF_FFFF; opB = 32'h1234_5678; ALUop = 4'b1000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst.in_ready", 64'(in_ready), 64'd1);
      chk("midrst.out_valid", 64'(out_valid), 64'd0);
      chk("midrst.result", 64'(result), 64'd0);
      chk("midrst.result_hi", 64'(result_hi), 64'd0);
      chk("midrst.flags", 64'({zero, overflow, div_by_zero}), 64'd0);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      chk("midrst.no_stale", 64'(saw_valid), 64'd0);

      // Directed corner cases
      run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
      run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
      run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 0);
      run_op("slt_neg", 4'b0111, 32'h8000_0000, 32'h0000_0001, 0);
      run_op("slt_pos", 4'b0111, 32'h0000_0001, 32'h8000_0000, 0);
      run_op("nor", 4'b1100, 32'h0F0F_0000, 32'h0000_00FF, 1);
      run_op("mul_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mul_zero", 4'b1000, 32'h0, 32'hDEAD_BEEF, 0);
      run_op("and_bp", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 10);
      run_op("div_100_7", 4'b1010, 32'd100, 32'd7, 0);
      run_op("div_9_0", 4'b1010, 32'd9, 32'd0, 2);
      run_op("div_small", 4'b1010, 32'd3, 32'hFFFF_FFFF, 0);
      run_op("bad_op", 4'b1111, 32'h1234_5678, 32'h1, 0);

      // Randomized requests
      for (int n = 0; n < 40; n++) begin
         run_op($sformatf("rnd%0d", n), op_tab[$urandom_range(0, 9)],
                rand_operand(), rand_operand(), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
